// File: rtl/instr_fetch_stage.sv
// instr_fetch_stage: PC, instruction RAM fetch sequencing and opcode/mode/operand stage register
// A fetch takes IDLE -> ISSUE -> (WAIT)* -> LATCH -> IDLE; RAM controls are decoded from state.
module instr_fetch_stage #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16,
  parameter int RAM_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fetch_req,
  input  logic               pc_load,
  input  logic [ADDR_W-1:0]  pc_load_val,
  input  logic [INSTR_W-1:0] InstrRAMdata,
  output logic [ADDR_W-1:0]  InstrRAMaddr,
  output logic               InstrRAMenable,
  output logic               InstrRAMread_en,
  output logic [4:0]         StageRegInstr_out,
  output logic [2:0]         StageRegAddrMode_out,
  output logic [INSTR_W-9:0] StageRegOperand_out,
  output logic               instr_valid,
  output logic               busy,
  output logic [ADDR_W-1:0]  pc_out
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, LATCH} state_t;
  localparam logic [2:0] CNT_INIT = (RAM_LAT > 1) ? 3'(RAM_LAT - 2) : 3'd0;
  state_t             r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_addr;
  logic [2:0]         r_cnt;
  logic [4:0]         r_instr;
  logic [2:0]         r_mode;
  logic [INSTR_W-9:0] r_opd;
  logic               r_valid;
  logic               w_active;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state <= IDLE;
      r_pc    <= '0;
      r_addr  <= '0;
      r_cnt   <= '0;
      r_instr <= '0;
      r_mode  <= '0;
      r_opd   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (pc_load) r_pc <= pc_load_val;
          if (fetch_req) begin
            r_addr  <= pc_load ? pc_load_val : r_pc;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          r_cnt   <= CNT_INIT;
          r_state <= (RAM_LAT == 1) ? LATCH : WAIT;
        end
        WAIT: begin
          if (r_cnt == 3'd0) r_state <= LATCH;
          else r_cnt <= r_cnt - 3'd1;
        end
        LATCH: begin
          r_instr <= InstrRAMdata[INSTR_W-1 -: 5];
          r_mode  <= InstrRAMdata[INSTR_W-6 -: 3];
          r_opd   <= InstrRAMdata[INSTR_W-9:0];
          r_pc    <= r_addr + 1'b1;
          r_valid <= 1'b1;
          r_state <= IDLE;
        end
      endcase
    end
  assign w_active             = r_state != IDLE;
  assign InstrRAMaddr         = w_active ? r_addr : r_pc;
  assign InstrRAMenable       = w_active;
  assign InstrRAMread_en      = w_active;
  assign busy                 = w_active;
  assign instr_valid          = r_valid;
  assign pc_out               = r_pc;
  assign StageRegInstr_out    = r_instr;
  assign StageRegAddrMode_out = r_mode;
  assign StageRegOperand_out  = r_opd;
endmodule

// File: tb/tb_instr_fetch_stage.sv
// tb_instr_fetch_stage: scoreboard bench for instr_fetch_stage at RAM_LAT=1 (u_a) and RAM_LAT=3 (u_b)
module tb_instr_fetch_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_a, req_a, ld_a, en_a, rd_a, vld_a, busy_a;
  logic rst_b, req_b, ld_b, en_b, rd_b, vld_b, busy_b;
  logic [7:0] ldv_a, addr_a, opd_a, pc_a, ldv_b, addr_b, opd_b, pc_b;
  logic [15:0] data_a, data_b, p0, p1, p2;
  logic [4:0] ins_a, ins_b;
  logic [2:0] mode_a, mode_b;
  logic [15:0] mem [256];
  int n_chk = 0, n_err = 0;
  typedef struct packed {logic [4:0] i; logic [2:0] m; logic [7:0] o; logic [7:0] pc;} exp_t;
  exp_t q_a[$], q_b[$];

  instr_fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RAM_LAT(1)) u_a (
    .clk(clk), .reset(rst_a), .fetch_req(req_a), .pc_load(ld_a), .pc_load_val(ldv_a),
    .InstrRAMdata(data_a), .InstrRAMaddr(addr_a), .InstrRAMenable(en_a), .InstrRAMread_en(rd_a),
    .StageRegInstr_out(ins_a), .StageRegAddrMode_out(mode_a), .StageRegOperand_out(opd_a),
    .instr_valid(vld_a), .busy(busy_a), .pc_out(pc_a));

  instr_fetch_stage #(.ADDR_W(8), .INSTR_W(16), .RAM_LAT(3)) u_b (
    .clk(clk), .reset(rst_b), .fetch_req(req_b), .pc_load(ld_b), .pc_load_val(ldv_b),
    .InstrRAMdata(data_b), .InstrRAMaddr(addr_b), .InstrRAMenable(en_b), .InstrRAMread_en(rd_b),
    .StageRegInstr_out(ins_b), .StageRegAddrMode_out(mode_b), .StageRegOperand_out(opd_b),
    .instr_valid(vld_b), .busy(busy_b), .pc_out(pc_b));

  // RAM models: one and three register stages of read latency
  always @(posedge clk) data_a <= mem[addr_a];
  always @(posedge clk) begin
    p0 <= mem[addr_b];
    p1 <= p0;
    p2 <= p1;
  end
  assign data_b = p2;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] a, input logic [7:0] pc);
    logic [15:0] w;
    w = mem[a];
    return {w[15:11], w[10:8], w[7:0], pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input bit sel);
    int n;
    n = 0;
    while ((sel ? busy_b : busy_a) && n < 20) begin
      tick();
      n++;
    end
    chk("idle_wait", {31'd0, sel ? busy_b : busy_a}, 0);
  endtask

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (vld_a) begin
      if (q_a.size() == 0) chk("unexp_vld_a", 1, 0);
      else begin
        e = q_a.pop_front();
        chk("instr_a", ins_a, e.i);
        chk("mode_a", mode_a, e.m);
        chk("opd_a", opd_a, e.o);
        chk("pc_a", pc_a, e.pc);
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (vld_b) begin
      if (q_b.size() == 0) chk("unexp_vld_b", 1, 0);
      else begin
        e = q_b.pop_front();
        chk("instr_b", ins_b, e.i);
        chk("mode_b", mode_b, e.m);
        chk("opd_b", opd_b, e.o);
        chk("pc_b", pc_b, e.pc);
      end
    end
  end

  initial begin
    rst_a = 1; rst_b = 1;
    req_a = 0; ld_a = 0; ldv_a = 0;
    req_b = 0; ld_b = 0; ldv_b = 0;
    for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37 + 5);
    mem[0] = 16'hA5C3;
    tick(); tick();
    chk("rst_addr", addr_a, 0);
    chk("rst_en", en_a, 0);
    chk("rst_rd", rd_a, 0);
    chk("rst_instr", ins_a, 0);
    chk("rst_opd", opd_a, 0);
    chk("rst_vld", vld_a, 0);
    chk("rst_busy", busy_a, 0);
    chk("rst_pc", pc_a, 0);
    chk("rst_en_b", en_b, 0);
    rst_a = 0; rst_b = 0;
    tick();
    // basic fetch, RAM_LAT=1
    req_a = 1;
    q_a.push_back(mk(8'h00, 8'h01));
    tick();
    req_a = 0;
    chk("iss_en", en_a, 1);
    chk("iss_rd", rd_a, 1);
    chk("iss_addr", addr_a, 0);
    tick();
    chk("e1_vld", vld_a, 0);
    chk("e1_busy", busy_a, 1);
    tick();
    chk("e2_vld", vld_a, 1);
    chk("e2_pc", pc_a, 1);
    chk("e2_en", en_a, 0);
    tick();
    chk("vld_pulse", vld_a, 0);
    chk("hold_instr", ins_a, 5'b10100);
    chk("hold_mode", mode_a, 3'b101);
    // reset in LATCH aborts and clears immediately
    req_a = 1;
    tick();
    req_a = 0;
    tick();
    #2 rst_a = 1;
    #1;
    chk("arst_en", en_a, 0);
    chk("arst_rd", rd_a, 0);
    chk("arst_busy", busy_a, 0);
    chk("arst_pc", pc_a, 0);
    chk("arst_addr", addr_a, 0);
    chk("arst_instr", ins_a, 0);
    chk("arst_opd", opd_a, 0);
    tick();
    rst_a = 0;
    tick();
    chk("arst_novld", vld_a, 0);
    // pc_load with fetch in IDLE, PC wrap
    mem[8'hFF] = 16'h1234;
    ld_a = 1; ldv_a = 8'hFF; req_a = 1;
    q_a.push_back(mk(8'hFF, 8'h00));
    tick();
    ld_a = 0; req_a = 0; ldv_a = 8'h00;
    chk("ld_addr", addr_a, 8'hFF);
    chk("ld_pc", pc_a, 8'hFF);
    wait_idle(0);
    chk("wrap_pc", pc_a, 8'h00);
    // back-to-back fetches
    mem[0] = 16'h0001; mem[1] = 16'h0002; mem[2] = 16'h0003;
    for (int k = 0; k < 3; k++) q_a.push_back(mk(8'(k), 8'(k + 1)));
    req_a = 1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("b2b_addr", addr_a, k);
      chk("b2b_en", en_a, 1);
      if (k == 2) req_a = 0;
      else begin
        tick(); tick();
      end
    end
    wait_idle(0);
    chk("b2b_pc", pc_a, 3);
    // RAM_LAT=3 with ignored pc_load during WAIT
    mem[0] = 16'hA5C3;
    q_b.push_back(mk(8'h00, 8'h01));
    req_b = 1;
    tick();
    req_b = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) tick();
      chk("l3_en", en_b, 1);
      chk("l3_rd", rd_b, 1);
      chk("l3_addr", addr_b, 0);
      chk("l3_vld", vld_b, 0);
      chk("l3_pc", pc_b, 0);
      ld_b = (k == 1);
      ldv_b = 8'h77;
    end
    ld_b = 0;
    tick();
    chk("l3_vld_e4", vld_b, 1);
    chk("l3_en_e4", en_b, 0);
    chk("l3_pc_e4", pc_b, 1);
    // reset during WAIT
    req_b = 1;
    tick();
    req_b = 0;
    tick();
    chk("w_busy", busy_b, 1);
    #2 rst_b = 1;
    #1;
    chk("wrst_en", en_b, 0);
    chk("wrst_rd", rd_b, 0);
    chk("wrst_busy", busy_b, 0);
    chk("wrst_pc", pc_b, 0);
    chk("wrst_instr", ins_b, 0);
    chk("wrst_mode", mode_b, 0);
    chk("wrst_opd", opd_b, 0);
    tick();
    rst_b = 0;
    q_b.push_back(mk(8'h00, 8'h01));
    req_b = 1;
    tick();
    req_b = 0;
    chk("post_rst_addr", addr_b, 0);
    wait_idle(1);
    repeat (3) tick();
    chk("q_a_empty", q_a.size(), 0);
    chk("q_b_empty", q_b.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
